// File: rtl/datapath.sv
// Accumulator datapath: acc register, add/sub ALU, data RAM strobes, one-cycle load wait state.
// Optional sticky signed-overflow flag is built when DATAPATH_OVERFLOW_EN is defined.
module datapath #(
  parameter int NB_DATA       = 16,
  parameter int NB_OPERAND    = 11,
  parameter int NB_SELECTOR_A = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [NB_OPERAND-1:0]    i_operand,
  input  logic [NB_SELECTOR_A-1:0] i_sel_a,
  input  logic                     i_sel_b,
  input  logic                     i_enb_acc,
  input  logic                     i_operation,
  input  logic                     i_wr_enb_ram,
  input  logic                     i_rd_enb_ram,
  input  logic [NB_DATA-1:0]       i_ram_data,
  output logic [NB_OPERAND-1:0]    o_ram_addr,
  output logic [NB_DATA-1:0]       o_ram_data,
  output logic                     o_ram_wr_enb,
  output logic                     o_ram_rd_enb,
  output logic                     o_stall,
  output logic [NB_DATA-1:0]       o_acc,
  output logic                     o_overflow
);

  typedef enum logic {EXEC, WAIT} state_t;

  typedef struct packed {
    logic [NB_SELECTOR_A-1:0] sel_a;
    logic                     sel_b;
    logic                     op;
  } ctrl_t;

  state_t             state, state_nxt;
  ctrl_t              cap, cap_nxt, live, cur;
  logic [NB_DATA-1:0] acc, acc_nxt, imm, opb, alu;
  logic               acc_wr, wr_enb, rd_enb, stall;

  assign live = '{sel_a: i_sel_a, sel_b: i_sel_b, op: i_operation};
  // The instruction is held during WAIT, but the captured copy decides the write.
  assign cur  = (state == WAIT) ? cap : live;

  assign imm = {{(NB_DATA-NB_OPERAND){i_operand[NB_OPERAND-1]}}, i_operand};
  assign opb = cur.sel_b ? imm : i_ram_data;
  assign alu = cur.op ? (acc - opb) : (acc + opb);

  always_comb begin
    case (cur.sel_a)
      2'b00:   acc_nxt = i_ram_data;
      2'b01:   acc_nxt = imm;
      2'b10:   acc_nxt = alu;
      default: acc_nxt = acc;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cap_nxt   = cap;
    acc_wr    = 1'b0;
    wr_enb    = 1'b0;
    rd_enb    = 1'b0;
    stall     = 1'b0;
    case (state)
      EXEC: begin
        if (i_wr_enb_ram) begin
          wr_enb = 1'b1;
        end else if (i_rd_enb_ram) begin
          rd_enb = 1'b1;
          if (i_enb_acc) begin
            stall     = 1'b1;
            cap_nxt   = live;
            state_nxt = WAIT;
          end
        end else if (i_enb_acc) begin
          acc_wr = 1'b1;
        end
      end
      WAIT: begin
        acc_wr    = 1'b1;
        state_nxt = EXEC;
      end
      default: state_nxt = EXEC;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= EXEC;
      cap   <= '0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      cap   <= cap_nxt;
      if (acc_wr) acc <= acc_nxt;
    end
  end

`ifdef DATAPATH_OVERFLOW_EN
  logic ovf_alu, ovf;

  // Add overflows on like-signed operands, subtract on unlike-signed ones.
  always_comb begin
    if (cur.op)
      ovf_alu = (acc[NB_DATA-1] != opb[NB_DATA-1]) && (alu[NB_DATA-1] != acc[NB_DATA-1]);
    else
      ovf_alu = (acc[NB_DATA-1] == opb[NB_DATA-1]) && (alu[NB_DATA-1] != acc[NB_DATA-1]);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)
      ovf <= 1'b0;
    else if (acc_wr && (cur.sel_a == 2'b10) && ovf_alu)
      ovf <= 1'b1;
  end

  assign o_overflow = ovf;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_ram_addr   = i_operand;
  assign o_ram_data   = acc;
  assign o_ram_wr_enb = wr_enb & ~i_reset;
  assign o_ram_rd_enb = rd_enb & ~i_reset;
  assign o_stall      = stall & ~i_reset;
  assign o_acc        = acc;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath with a behavioural synchronous data RAM.
module tb_datapath;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, enb_acc, op, wr, rd;
  logic [15:0] ram_q;
  logic [10:0] ram_addr;
  logic [15:0] ram_wdata, acc;
  logic        ram_wr_enb, ram_rd_enb, stall, ovf;

  logic        pre_wr;
  logic [10:0] pre_addr;
  logic [15:0] pre_data;
  logic [15:0] mem [0:2047];

  int ncmp = 0;
  int nfail = 0;

`ifdef DATAPATH_OVERFLOW_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  datapath #(.NB_DATA(16), .NB_OPERAND(11), .NB_SELECTOR_A(2)) dut (
    .i_clock(clk), .i_reset(rst), .i_operand(operand), .i_sel_a(sel_a),
    .i_sel_b(sel_b), .i_enb_acc(enb_acc), .i_operation(op),
    .i_wr_enb_ram(wr), .i_rd_enb_ram(rd), .i_ram_data(ram_q),
    .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .o_ram_wr_enb(ram_wr_enb),
    .o_ram_rd_enb(ram_rd_enb), .o_stall(stall), .o_acc(acc), .o_overflow(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_wr) mem[pre_addr] <= pre_data;
    else if (ram_wr_enb) mem[ram_addr] <= ram_wdata;
    if (rst) ram_q <= '0;
    else if (ram_rd_enb) ram_q <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [10:0] a, input logic [15:0] d);
    pre_wr = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_wr = 1'b0;
  endtask

  task automatic drive(input logic [1:0] sa, input logic sb, input logic en,
                       input logic o, input logic w, input logic r, input logic [10:0] opd);
    sel_a = sa; sel_b = sb; enb_acc = en; op = o; wr = w; rd = r; operand = opd;
    #1;
  endtask

  initial begin
    pre_wr = 1'b0; pre_addr = '0; pre_data = '0;
    rst = 1'b1;
    // Strobe requests held high during reset must stay masked.
    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd0);
    preload(11'd5, 16'h1234);
    preload(11'd6, 16'h0010);
    preload(11'd7, 16'h7FFF);
    preload(11'd8, 16'hABCD);
    chk("rst_acc", acc, 16'h0000);
    chk("rst_ovf", {15'd0, ovf}, 16'd0);
    chk("rst_stall", {15'd0, stall}, 16'd0);
    chk("rst_wr", {15'd0, ram_wr_enb}, 16'd0);
    chk("rst_rd", {15'd0, ram_rd_enb}, 16'd0);
    rst = 1'b0;

    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FB);
    chk("ldi_stall", {15'd0, stall}, 16'd0);
    tick();
    chk("ldi_acc", acc, 16'hFFFB);

    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd5);
    chk("ldm_rd", {15'd0, ram_rd_enb}, 16'd1);
    chk("ldm_stall", {15'd0, stall}, 16'd1);
    chk("ldm_addr", {5'd0, ram_addr}, 16'd5);
    tick();
    chk("ldm_wait_stall", {15'd0, stall}, 16'd0);
    chk("ldm_wait_rd", {15'd0, ram_rd_enb}, 16'd0);
    chk("ldm_wait_acc", acc, 16'hFFFB);
    tick();
    chk("ldm_acc", acc, 16'h1234);

    // Back-to-back memory add; live sel_a is scrambled during WAIT.
    drive(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd6);
    chk("b2b_stall", {15'd0, stall}, 16'd1);
    tick();
    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd6);
    chk("b2b_wait_stall", {15'd0, stall}, 16'd0);
    tick();
    chk("addm_acc", acc, 16'h1244);
    chk("addm_ovf", {15'd0, ovf}, 16'd0);

    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'h7FB);
    tick();
    chk("addi_neg_acc", acc, 16'h123F);
    drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'h00F);
    tick();
    chk("subi_acc", acc, 16'h1230);
    chk("subi_ovf", {15'd0, ovf}, 16'd0);

    drive(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h123);
    tick();
    chk("hold_acc", acc, 16'h1230);

    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd7);
    tick(); tick();
    chk("ld7fff_acc", acc, 16'h7FFF);
    drive(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1);
    tick();
    chk("ovf_add_acc", acc, 16'h8000);
    chk("ovf_add_flag", {15'd0, ovf}, {15'd0, OVF_EXP});
    drive(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd1);
    tick();
    chk("ovf_sub_acc", acc, 16'h7FFF);
    chk("ovf_sticky", {15'd0, ovf}, {15'd0, OVF_EXP});

    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd8);
    tick(); tick();
    chk("ldabcd_acc", acc, 16'hABCD);
    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 11'd3);
    chk("st_wr", {15'd0, ram_wr_enb}, 16'd1);
    chk("st_addr", {5'd0, ram_addr}, 16'd3);
    chk("st_data", ram_wdata, 16'hABCD);
    chk("st_rd", {15'd0, ram_rd_enb}, 16'd0);
    chk("st_stall", {15'd0, stall}, 16'd0);
    tick();
    chk("st_acc", acc, 16'hABCD);
    chk("st_mem", mem[3], 16'hABCD);

    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd5);
    chk("rdnoacc_rd", {15'd0, ram_rd_enb}, 16'd1);
    chk("rdnoacc_stall", {15'd0, stall}, 16'd0);
    tick();
    drive(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd2);
    chk("rdnoacc_next_stall", {15'd0, stall}, 16'd0);
    tick();
    chk("rdnoacc_acc", acc, 16'h0002);

    drive(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd5);
    tick();
    rst = 1'b1;
    #1;
    chk("rstw_rd", {15'd0, ram_rd_enb}, 16'd0);
    chk("rstw_stall", {15'd0, stall}, 16'd0);
    tick();
    rst = 1'b0;
    chk("rstw_acc", acc, 16'h0000);
    chk("rstw_ovf", {15'd0, ovf}, 16'd0);
    #1;
    chk("rstw_exec_stall", {15'd0, stall}, 16'd1);
    tick(); tick();
    chk("rstw_reload_acc", acc, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
